// File: rtl/qpsk_peak_slicer.sv
// ----------------------------------------------------------------------------
// qpsk_peak_slicer
//
// Purpose:
//   Slices I/Q correlator match counts from a spread-spectrum QPSK receiver
//   into dibits. The block hunts for a correlation peak or anti-peak (SEARCH).
//   Once it finds one, it tracks the spreading period (TRACK). While tracking,
//   it accepts one peak per period inside a small circular window around the
//   expected phase and re-centres on it. It drops lock after MISS_MAX
//   consecutive empty windows.
//
// Parameters:
//   PERIOD   - spreading period in valid input samples (m-sequence length)
//   THR      - match-count threshold for a peak (>= THR) or an anti-peak
//              (<= 31-THR), range 17..31
//   WIN      - tracking window half-width in samples, range 0..7
//   MISS_MAX - consecutive missed windows before lock is dropped, 1..15
//
// Ports:
//   CLK_50MHZ     in   1   sole clock, rising edge
//   RST_N         in   1   asynchronous active-low reset
//   in_valid      in   1   corr_i/corr_q carry a sample this cycle
//   corr_i        in   8   I-channel match count, unsigned
//   corr_q        in   8   Q-channel match count, unsigned
//   sym_valid     out  1   one-cycle strobe: a new dibit is on sym
//   sym           out  2   decided dibit {I,Q}, held until the next symbol
//   locked        out  1   high while in TRACK
//
// Optional feature (macro QPSK_PEAK_STATS_EN):
//   sym_cnt       out  16  symbols emitted, saturating
//   lock_loss_cnt out  8   TRACK->SEARCH transitions, saturating
// ----------------------------------------------------------------------------
module qpsk_peak_slicer #(
    parameter int PERIOD   = 31,
    parameter int THR      = 28,
    parameter int WIN      = 2,
    parameter int MISS_MAX = 3
) (
    input  logic       CLK_50MHZ,
    input  logic       RST_N,
    input  logic       in_valid,
    input  logic [7:0] corr_i,
    input  logic [7:0] corr_q,
    output logic       sym_valid,
    output logic [1:0] sym,
`ifdef QPSK_PEAK_STATS_EN
    output logic [15:0] sym_cnt,
    output logic [7:0]  lock_loss_cnt,
`endif
    output logic       locked
);

    localparam int            PW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(PERIOD - 1);
    localparam logic [4:0]    THR_HI   = 5'(THR);
    localparam logic [4:0]    THR_LO   = 5'(31 - THR);
    localparam logic [3:0]    MISS_LIM = 4'(MISS_MAX);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_TRACK  = 1'b1
    } state_t;

    // Clamp a match count to the 5-bit range a 31-chip correlator can produce.
    function automatic logic [4:0] sat5(input logic [7:0] x);
        logic [4:0] r;
        if (x > 8'd31) begin
            r = 5'd31;
        end else begin
            r = x[4:0];
        end
        return r;
    endfunction

    // A strong positive or strong negative correlation both mark a symbol.
    function automatic logic is_peak(input logic [4:0] v);
        return (v >= THR_HI) || (v <= THR_LO);
    endfunction

    state_t        state_r, state_nx;
    logic [PW-1:0] phase_r, phase_nx;
    logic [3:0]    miss_r, miss_nx;
    logic          got_r, got_nx;       // current window already produced a symbol
    logic          run_r;               // low only until the first edge after reset
    logic          sym_valid_r, sym_valid_nx;
    logic [1:0]    sym_r, sym_nx;
    logic          locked_r, locked_nx;

    logic [4:0]    ci_s, cq_s;
    logic          hit_s;
    logic [1:0]    dibit_s;
    logic [PW-1:0] ph_adv_s;
    logic          win_s;
    logic          close_s;
    logic          emit_s;
    logic          drop_s;

`ifdef QPSK_PEAK_STATS_EN
    logic [15:0] sym_cnt_r, sym_cnt_nx;
    logic [7:0]  lock_loss_cnt_r, lock_loss_cnt_nx;
`endif

    // Sample decode: saturation, hit detection, dibit decision, window geometry.
    always_comb begin
        ci_s    = sat5(corr_i);
        cq_s    = sat5(corr_q);
        hit_s   = is_peak(ci_s) || is_peak(cq_s);
        dibit_s = {(ci_s >= 5'd16), (cq_s >= 5'd16)};
        if (phase_r == PH_LAST) begin
            ph_adv_s = '0;
        end else begin
            ph_adv_s = phase_r + {{(PW-1){1'b0}}, 1'b1};
        end
        // The window wraps through phase 0: [PERIOD-WIN, PERIOD-1] U [0, WIN].
        win_s   = (int'(ph_adv_s) >= PERIOD - WIN) || (int'(ph_adv_s) <= WIN);
        // The window closes on the first sample past WIN.
        close_s = (int'(ph_adv_s) == WIN + 1);
    end

    // Next-state logic for the acquisition/tracking FSM and the registered outputs.
    always_comb begin
        state_nx     = state_r;
        phase_nx     = phase_r;
        miss_nx      = miss_r;
        got_nx       = got_r;
        emit_s       = 1'b0;
        drop_s       = 1'b0;
        if (run_r && in_valid) begin
            case (state_r)
                ST_SEARCH: begin
                    if (hit_s) begin
                        emit_s   = 1'b1;
                        state_nx = ST_TRACK;
                        phase_nx = '0;
                        miss_nx  = 4'd0;
                        got_nx   = 1'b1;
                    end else begin
                        phase_nx = '0;
                    end
                end
                ST_TRACK: begin
                    phase_nx = ph_adv_s;
                    if (hit_s && win_s && !got_r) begin
                        // Re-centre: this sample becomes phase 0.
                        emit_s   = 1'b1;
                        phase_nx = '0;
                        miss_nx  = 4'd0;
                        got_nx   = 1'b1;
                    end else if (close_s) begin
                        got_nx = 1'b0;
                        if (!got_r) begin
                            if ((miss_r + 4'd1) >= MISS_LIM) begin
                                drop_s   = 1'b1;
                                state_nx = ST_SEARCH;
                                phase_nx = '0;
                                miss_nx  = 4'd0;
                            end else begin
                                miss_nx = miss_r + 4'd1;
                            end
                        end else begin
                            miss_nx = miss_r;
                        end
                    end else begin
                        got_nx = got_r;
                    end
                end
                default: begin
                    state_nx = ST_SEARCH;
                    phase_nx = '0;
                    miss_nx  = 4'd0;
                    got_nx   = 1'b0;
                end
            endcase
        end else begin
            state_nx = state_r;
        end

        sym_valid_nx = emit_s;
        if (emit_s) begin
            sym_nx = dibit_s;
        end else begin
            sym_nx = sym_r;
        end
        locked_nx = (state_nx == ST_TRACK);
    end

`ifdef QPSK_PEAK_STATS_EN
    // Saturating statistics counters.
    always_comb begin
        sym_cnt_nx       = sym_cnt_r;
        lock_loss_cnt_nx = lock_loss_cnt_r;
        if (emit_s && (sym_cnt_r != 16'hFFFF)) begin
            sym_cnt_nx = sym_cnt_r + 16'd1;
        end else begin
            sym_cnt_nx = sym_cnt_r;
        end
        if (drop_s && (lock_loss_cnt_r != 8'hFF)) begin
            lock_loss_cnt_nx = lock_loss_cnt_r + 8'd1;
        end else begin
            lock_loss_cnt_nx = lock_loss_cnt_r;
        end
    end

    // Statistics registers.
    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            sym_cnt_r       <= 16'd0;
            lock_loss_cnt_r <= 8'd0;
        end else begin
            sym_cnt_r       <= sym_cnt_nx;
            lock_loss_cnt_r <= lock_loss_cnt_nx;
        end
    end

    assign sym_cnt       = sym_cnt_r;
    assign lock_loss_cnt = lock_loss_cnt_r;
`endif

    // State, tracking and output registers.
    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_SEARCH;
            phase_r     <= '0;
            miss_r      <= 4'd0;
            got_r       <= 1'b0;
            run_r       <= 1'b0;
            sym_valid_r <= 1'b0;
            sym_r       <= 2'b00;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_nx;
            phase_r     <= phase_nx;
            miss_r      <= miss_nx;
            got_r       <= got_nx;
            run_r       <= 1'b1;
            sym_valid_r <= sym_valid_nx;
            sym_r       <= sym_nx;
            locked_r    <= locked_nx;
        end
    end

    assign sym_valid = sym_valid_r;
    assign sym       = sym_r;
    assign locked    = locked_r;

endmodule
